// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter: grants up to two register writes per cycle in round-robin
// order onto the register file's two write ports through a registered stage.
module rf_wb_arbiter #(
  parameter int NREQ     = 4,
  parameter int AWIDTH   = 5,
  parameter int DWIDTH   = 32,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hold,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*AWIDTH-1:0] req_addr,
  input  logic [NREQ*DWIDTH-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic [AWIDTH-1:0]      WA,
  output logic [AWIDTH-1:0]      WB,
  output logic                   WEA,
  output logic                   WEB,
  output logic [DWIDTH-1:0]      WAData,
  output logic [DWIDTH-1:0]      WBData
);
  localparam int PW = $clog2(NREQ);

  logic [AWIDTH-1:0] addr_arr [NREQ];
  logic [DWIDTH-1:0] data_arr [NREQ];

  logic [PW-1:0]     ptr;
  logic [PW-1:0]     ptr_next;
  logic              a_gnt, b_gnt;
  logic [PW-1:0]     a_idx, b_idx;
  logic [AWIDTH-1:0] a_addr, b_addr;
  logic [DWIDTH-1:0] a_data, b_data;
  logic [PW:0]       scan;
  logic [PW-1:0]     idx;
  logic [PW:0]       last_inc;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      addr_arr[i] = req_addr[i*AWIDTH +: AWIDTH];
      data_arr[i] = req_data[i*DWIDTH +: DWIDTH];
    end
  end

  // Port B skips requesters whose address matches port A; they retry next cycle.
  always_comb begin
    a_gnt     = 1'b0;
    b_gnt     = 1'b0;
    a_idx     = '0;
    b_idx     = '0;
    a_addr    = '0;
    b_addr    = '0;
    a_data    = '0;
    b_data    = '0;
    scan      = '0;
    idx       = '0;
    req_ready = '0;
    if (!rst && !hold) begin
      for (int k = 0; k < NREQ; k++) begin
        scan = {1'b0, ptr} + (PW+1)'(k);
        if (scan >= (PW+1)'(NREQ)) scan = scan - (PW+1)'(NREQ);
        idx = scan[PW-1:0];
        if (req_valid[idx]) begin
          if (!a_gnt) begin
            a_gnt  = 1'b1;
            a_idx  = idx;
            a_addr = addr_arr[idx];
            a_data = data_arr[idx];
          end else if (!b_gnt && addr_arr[idx] != a_addr) begin
            b_gnt  = 1'b1;
            b_idx  = idx;
            b_addr = addr_arr[idx];
            b_data = data_arr[idx];
          end
        end
      end
      if (a_gnt) req_ready[a_idx] = 1'b1;
      if (b_gnt) req_ready[b_idx] = 1'b1;
    end
  end

  always_comb begin
    last_inc = {1'b0, (b_gnt ? b_idx : a_idx)} + (PW+1)'(1);
    ptr_next = (last_inc == (PW+1)'(NREQ)) ? '0 : last_inc[PW-1:0];
  end

  // Address/data only load on a grant so idle ports do not toggle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr    <= '0;
      WEA    <= 1'b0;
      WEB    <= 1'b0;
      WA     <= '0;
      WB     <= '0;
      WAData <= '0;
      WBData <= '0;
    end else begin
      WEA <= a_gnt && !(ZERO_REG && a_addr == '0);
      WEB <= b_gnt && !(ZERO_REG && b_addr == '0);
      if (a_gnt) begin
        WA     <= a_addr;
        WAData <= a_data;
        ptr    <= ptr_next;
      end
      if (b_gnt) begin
        WB     <= b_addr;
        WBData <= b_data;
      end
    end
  end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: a queue-based grant model predicts ready
// bits and next-cycle port outputs; a negedge monitor checks the port stage.
module tb_rf_wb_arbiter;
  localparam int NREQ = 4;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hold = 1'b0;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic [NREQ-1:0]    req_ready;
  logic [AW-1:0]      WA, WB;
  logic               WEA, WEB;
  logic [DW-1:0]      WAData, WBData;

  typedef struct packed {
    logic          wea;
    logic [AW-1:0] wa;
    logic [DW-1:0] wad;
    logic          web;
    logic [AW-1:0] wb;
    logic [DW-1:0] wbd;
  } out_t;

  out_t          exp_q[$];
  out_t          m_last = '0;
  int            m_ptr = 0;
  int            checks = 0;
  int            errors = 0;
  logic          pv[NREQ];
  logic [AW-1:0] pa[NREQ];
  logic [DW-1:0] pd[NREQ];
  bit            persist[NREQ];
  logic [DW-1:0] d_rf[32];

  rf_wb_arbiter #(.NREQ(NREQ), .AWIDTH(AW), .DWIDTH(DW), .ZERO_REG(1'b1)) dut (
    .clk(clk), .rst(rst), .hold(hold),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready),
    .WA(WA), .WB(WB), .WEA(WEA), .WEB(WEB), .WAData(WAData), .WBData(WBData)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]          = pv[i];
      req_addr[i*AW +: AW]  = pa[i];
      req_data[i*DW +: DW]  = pd[i];
    end
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit p);
    pv[i] = 1'b1; pa[i] = a; pd[i] = d; persist[i] = p;
  endtask

  task automatic clear_all();
    for (int i = 0; i < NREQ; i++) begin
      pv[i] = 1'b0; pa[i] = '0; pd[i] = '0; persist[i] = 1'b0;
    end
  endtask

  // Candidates in rotated order; A is the first, B the first later one with a different address.
  function automatic void model_grant(output int ga, output int gb);
    int cand[$];
    ga = -1; gb = -1;
    for (int k = 0; k < NREQ; k++)
      if (pv[(m_ptr + k) % NREQ]) cand.push_back((m_ptr + k) % NREQ);
    if (cand.size() > 0) ga = cand[0];
    foreach (cand[j])
      if (j > 0 && gb < 0 && pa[cand[j]] != pa[ga]) gb = cand[j];
  endfunction

  task automatic retire(input int i);
    if (persist[i]) pd[i] = $urandom;
    else pv[i] = 1'b0;
  endtask

  task automatic step(input bit r, input bit h, output logic [NREQ-1:0] act);
    int ga, gb;
    logic [NREQ-1:0] er;
    out_t e;
    rst = r; hold = h; drive();
    #1;
    ga = -1; gb = -1;
    if (!r && !h) model_grant(ga, gb);
    er = '0;
    if (ga >= 0) er = er | (NREQ'(1) << ga);
    if (gb >= 0) er = er | (NREQ'(1) << gb);
    act = req_ready;
    chk("ready", req_ready, er);
    e = m_last; e.wea = 1'b0; e.web = 1'b0;
    if (r) begin
      e = '0; m_ptr = 0;
    end else begin
      if (ga >= 0) begin e.wa = pa[ga]; e.wad = pd[ga]; e.wea = (pa[ga] != '0); end
      if (gb >= 0) begin e.wb = pa[gb]; e.wbd = pd[gb]; e.web = (pa[gb] != '0); end
      if (ga >= 0) m_ptr = ((gb >= 0 ? gb : ga) + 1) % NREQ;
    end
    m_last = e;
    @(posedge clk);
    exp_q.push_back(e);
    #1;
    if (ga >= 0) retire(ga);
    if (gb >= 0) retire(gb);
  endtask

  always @(negedge clk) begin
    out_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("wea", WEA, e.wea);
      chk("web", WEB, e.web);
      chk("wa", WA, e.wa);
      chk("wb", WB, e.wb);
      chk("wadata", WAData, e.wad);
      chk("wbdata", WBData, e.wbd);
      if (WEA === 1'b1) d_rf[WA] = WAData;
      if (WEB === 1'b1) d_rf[WB] = WBData;
    end
  end

  initial begin
    logic [NREQ-1:0] r;
    logic [DW-1:0] d2;
    int n;
    for (int i = 0; i < 32; i++) d_rf[i] = '0;
    clear_all();

    // reset with everyone valid, then full load on addresses 1..4
    for (int i = 0; i < NREQ; i++) set_req(i, AW'(i + 1), $urandom, 1'b1);
    step(1'b1, 1'b0, r); chk("rst_ready", r, 4'b0000);
    step(1'b0, 1'b0, r); chk("full_g0", r, 4'b0011);
    step(1'b0, 1'b0, r); chk("full_g1", r, 4'b1100);
    step(1'b0, 1'b0, r); chk("full_g2", r, 4'b0011);

    repeat (3) begin
      step(1'b0, 1'b1, r); chk("hold_ready", r, 4'b0000);
    end
    step(1'b0, 1'b0, r); chk("hold_resume", r, 4'b1100);

    // same-address conflict
    clear_all(); step(1'b1, 1'b0, r);
    for (int i = 0; i < 3; i++) set_req(i, AW'(7), $urandom, 1'b0);
    d2 = pd[2];
    step(1'b0, 1'b0, r); chk("conf_g0", r, 4'b0001);
    step(1'b0, 1'b0, r); chk("conf_g1", r, 4'b0010);
    step(1'b0, 1'b0, r); chk("conf_g2", r, 4'b0100);
    step(1'b0, 1'b0, r); step(1'b0, 1'b0, r);
    chk("conf_rf7", d_rf[7], d2);

    // skip-over
    clear_all(); step(1'b1, 1'b0, r);
    set_req(0, AW'(5), $urandom, 1'b0);
    set_req(1, AW'(5), $urandom, 1'b0);
    set_req(2, AW'(9), $urandom, 1'b0);
    step(1'b0, 1'b0, r); chk("skip_g0", r, 4'b0101);
    step(1'b0, 1'b0, r); chk("skip_g1", r, 4'b0010);

    // x0 suppression
    clear_all(); step(1'b1, 1'b0, r);
    set_req(0, AW'(0), 32'hDEADBEEF, 1'b0);
    step(1'b0, 1'b0, r); chk("x0_ready", r, 4'b0001);
    step(1'b0, 1'b0, r); step(1'b0, 1'b0, r);
    chk("x0_rf0", d_rf[0], '0);

    // single-requester stream
    for (int i = 0; i < NREQ; i++) begin
      clear_all();
      set_req(i, AW'($urandom_range(1, 31)), $urandom, 1'b0);
      for (n = 0; n < 4; n++) begin
        step(1'b0, 1'b0, r);
        if (((r >> i) & 4'b0001) != 4'b0000) break;
      end
      chk("stream_wait", 64'(n <= 3), 64'(1));
    end

    // random traffic with occasional hold and mid-run reset
    clear_all(); step(1'b1, 1'b0, r);
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++)
        if (!pv[i] && $urandom_range(0, 99) < 60)
          set_req(i, AW'($urandom_range(0, 7)), $urandom, 1'b0);
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 10, r);
    end

    clear_all();
    step(1'b0, 1'b0, r); step(1'b0, 1'b0, r);
    @(negedge clk); #1;
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
